conf_int_mul__seq_ctrl: RTL and testbench

//  Sequencer on the driving side of conf_int_mul__noFF__arch_agnos__w_wrapper.

---
 rtl/conf_int_mul__seq_ctrl.sv | 110 +++++++++++
 tb/tb_conf_int_mul__seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/conf_int_mul__seq_ctrl.sv
// Sequencer driving the conf_int_mul wrapper: primes count0, issues operand pairs
// into the wrapper load window and tags the 2-cycle-late products as a result stream.
module conf_int_mul__seq_ctrl #(
   parameter int DATA_PATH_BITWIDTH = 24,
   parameter int BLK_LEN            = 64,
   parameter int PRIME_LEN          = 64
) (
   input  logic                          clk,
   input  logic                          racc,
   input  logic                          start,
   input  logic                          apx_mode,
   output logic                          busy,
   output logic                          done,
   input  logic                          op_valid,
   output logic                          op_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0] op_a,
   input  logic [DATA_PATH_BITWIDTH-1:0] op_b,
   output logic [DATA_PATH_BITWIDTH-1:0] A_out,
   output logic [DATA_PATH_BITWIDTH-1:0] B_out,
   output logic [2:0]                    state_to_wrapper,
   output logic [8:0]                    count0,
   output logic                          rstP,
   output logic                          rapx,
   input  logic [31:0]                   P_in,
   output logic                          res_valid,
   output logic [31:0]                   res_data,
   output logic                          res_last
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_PRIME = 3'b001,
      S_RUN   = 3'b010,
      S_DRAIN = 3'b100
   } state_t;

   localparam logic [8:0] LAST_CNT = 9'(PRIME_LEN - 1);
   localparam logic [8:0] BLK      = 9'(BLK_LEN);
   localparam logic [8:0] BLK_M1   = 9'(BLK_LEN - 1);

   state_t     state, state_nxt;
   logic [8:0] issued;
   logic [1:0] drain_cnt;
   logic [1:0] v_pipe, l_pipe;
   logic       slot, accept, last_acc;

   // Slot 0 is the final PRIME cycle; every RUN cycle is a slot.
   assign slot     = (state == S_RUN) || ((state == S_PRIME) && (count0 == LAST_CNT));
   assign op_ready = slot && (issued < BLK);
   assign accept   = op_ready && op_valid;
   assign last_acc = accept && (issued == BLK_M1);

   assign A_out     = accept ? op_a : '0;
   assign B_out     = accept ? op_b : '0;
   assign busy      = (state != S_IDLE);
   assign rstP      = (state == S_IDLE);
   assign done      = (state == S_DRAIN) && (drain_cnt == 2'd2);
   assign res_valid = v_pipe[1];
   assign res_last  = l_pipe[1];
   assign res_data  = P_in;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nxt        = state;
      state_to_wrapper = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_PRIME;
         S_PRIME: if (count0 == LAST_CNT) state_nxt = last_acc ? S_DRAIN : S_RUN;
         S_RUN: begin
            state_to_wrapper = {2'b01, ~rapx};
            if (last_acc) state_nxt = S_DRAIN;
         end
         S_DRAIN: if (drain_cnt == 2'd2) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge racc) begin
      if (racc) begin
         state     <= S_IDLE;
         count0    <= '0;
         issued    <= '0;
         drain_cnt <= '0;
         rapx      <= 1'b0;
         v_pipe    <= '0;
         l_pipe    <= '0;
      end else begin
         state  <= state_nxt;
         v_pipe <= {v_pipe[0], accept};
         l_pipe <= {l_pipe[0], last_acc};

         if (state_nxt == S_IDLE)
            count0 <= '0;
         else if ((state == S_PRIME) && (count0 != LAST_CNT))
            count0 <= count0 + 9'd1;

         if (state == S_IDLE)
            issued <= '0;
         else if (accept)
            issued <= issued + 9'd1;

         drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;

         if ((state == S_IDLE) && start)
            rapx <= apx_mode;
      end
   end

endmodule

// File: tb/tb_conf_int_mul__seq_ctrl.sv
// Directed bench for conf_int_mul__seq_ctrl with a 2-stage signed multiplier
// standing in for the wrapper; a BLK_LEN=4 and a BLK_LEN=1 instance share inputs.
module tb_conf_int_mul__seq_ctrl;
   localparam int DPW = 24;

   logic clk = 1'b0;
   logic racc, start, apx_mode, op_valid;
   logic [DPW-1:0] op_a, op_b;
   always #5 clk = ~clk;

   // BLK_LEN=4 instance
   logic w4_busy, w4_done, w4_ready, w4_rstP, w4_rapx, w4_rvalid, w4_rlast;
   logic [DPW-1:0] w4_a, w4_b;
   logic [2:0] w4_code;
   logic [8:0] w4_c0;
   logic [31:0] w4_p, w4_rdata;
   // BLK_LEN=1 instance
   logic w1_busy, w1_done, w1_ready, w1_rstP, w1_rapx, w1_rvalid, w1_rlast;
   logic [DPW-1:0] w1_a, w1_b;
   logic [2:0] w1_code;
   logic [8:0] w1_c0;
   logic [31:0] w1_p, w1_rdata;

   conf_int_mul__seq_ctrl #(.DATA_PATH_BITWIDTH(DPW), .BLK_LEN(4), .PRIME_LEN(64)) dut (
      .clk(clk), .racc(racc), .start(start), .apx_mode(apx_mode),
      .busy(w4_busy), .done(w4_done), .op_valid(op_valid), .op_ready(w4_ready),
      .op_a(op_a), .op_b(op_b), .A_out(w4_a), .B_out(w4_b),
      .state_to_wrapper(w4_code), .count0(w4_c0), .rstP(w4_rstP), .rapx(w4_rapx),
      .P_in(w4_p), .res_valid(w4_rvalid), .res_data(w4_rdata), .res_last(w4_rlast));

   conf_int_mul__seq_ctrl #(.DATA_PATH_BITWIDTH(DPW), .BLK_LEN(1), .PRIME_LEN(64)) dut1 (
      .clk(clk), .racc(racc), .start(start), .apx_mode(apx_mode),
      .busy(w1_busy), .done(w1_done), .op_valid(op_valid), .op_ready(w1_ready),
      .op_a(op_a), .op_b(op_b), .A_out(w1_a), .B_out(w1_b),
      .state_to_wrapper(w1_code), .count0(w1_c0), .rstP(w1_rstP), .rapx(w1_rapx),
      .P_in(w1_p), .res_valid(w1_rvalid), .res_data(w1_rdata), .res_last(w1_rlast));

   // Wrapper stand-in: operands sampled at t, product presented at t+2.
   logic signed [47:0] m4, m1;
   logic [31:0] p4, p1;
   always_ff @(posedge clk) begin
      m4 <= $signed(w4_a) * $signed(w4_b);
      m1 <= $signed(w1_a) * $signed(w1_b);
      p4 <= m4[31:0];
      p1 <= m1[31:0];
   end
   assign w4_p = p4;
   assign w1_p = p1;

   // Observed-instance select
   bit sel;
   logic o_busy, o_done, o_ready, o_rstP, o_rapx, o_rvalid, o_rlast;
   logic [DPW-1:0] o_a, o_b;
   logic [2:0] o_code;
   logic [8:0] o_c0;
   logic [31:0] o_rdata;
   assign o_busy   = sel ? w1_busy   : w4_busy;
   assign o_done   = sel ? w1_done   : w4_done;
   assign o_ready  = sel ? w1_ready  : w4_ready;
   assign o_rstP   = sel ? w1_rstP   : w4_rstP;
   assign o_rapx   = sel ? w1_rapx   : w4_rapx;
   assign o_rvalid = sel ? w1_rvalid : w4_rvalid;
   assign o_rlast  = sel ? w1_rlast  : w4_rlast;
   assign o_a      = sel ? w1_a      : w4_a;
   assign o_b      = sel ? w1_b      : w4_b;
   assign o_code   = sel ? w1_code   : w4_code;
   assign o_c0     = sel ? w1_c0     : w4_c0;
   assign o_rdata  = sel ? w1_rdata  : w4_rdata;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int pa [4] = '{3, -2, 100, 0};
   int pb [4] = '{5, 7, 100, 9};
   int pexp [4] = '{15, -14, 10000, 0};

   // Per-block recorders
   int cnt [8];
   int na, nr, ndone, a_bad, rapx_bad, pi, c0_first, c0_slot;
   int acc_cyc [8];
   int res_cyc [8];
   logic [31:0] res [8];
   logic res_l [8];

   task automatic load_pair();
      op_a = DPW'(pa[pi % 4]);
      op_b = DPW'(pb[pi % 4]);
   endtask

   task automatic run_block(input bit s, input bit apx, input int bub);
      int bub_left;
      bit cur_done;
      sel = s;
      foreach (cnt[i]) cnt[i] = 0;
      na = 0; nr = 0; ndone = 0; a_bad = 0; rapx_bad = 0; pi = 0;
      c0_first = -1; c0_slot = -1; bub_left = 0;
      apx_mode = apx; op_valid = 1'b1; load_pair();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 300; k++) begin
         #1;
         cnt[o_code]++;
         if (k == 0)  c0_first = int'(o_c0);
         if (k == 63) c0_slot = int'(o_c0);
         if (o_busy && (o_rapx !== apx)) rapx_bad++;
         if (op_valid && o_ready) begin
            if (na < 8) acc_cyc[na] = k;
            if ((o_a !== op_a) || (o_b !== op_b)) a_bad++;
            na++; pi++;
            if (na == 2) bub_left = bub;
         end else if ((o_a !== '0) || (o_b !== '0)) a_bad++;
         if (o_rvalid && nr < 8) begin
            res[nr] = o_rdata; res_cyc[nr] = k; res_l[nr] = o_rlast; nr++;
         end
         if (o_done) ndone++;
         cur_done = o_done;
         tick();
         if (cur_done) break;
         load_pair();
         op_valid = (bub_left == 0);
         if (bub_left > 0) bub_left--;
      end
   endtask

   task automatic check_block(input string t, input int run_code, input int run_n, input int n);
      check({t, " prime_cycles"}, cnt[1], 64);
      check({t, " run_cycles"}, cnt[run_code], run_n);
      check({t, " other_run_code"}, cnt[run_code ^ 1], 0);
      check({t, " drain_cycles"}, cnt[4], 3);
      check({t, " count0_first"}, c0_first, 0);
      check({t, " count0_slot0"}, c0_slot, 63);
      check({t, " done_pulses"}, ndone, 1);
      check({t, " accepted"}, na, n);
      check({t, " results"}, nr, n);
      check({t, " operand_out"}, a_bad, 0);
      check({t, " rapx_held"}, rapx_bad, 0);
      check({t, " idle_after"}, o_code, 3'b000);
      for (int i = 0; i < n && i < nr; i++) begin
         check($sformatf("%s res_data[%0d]", t, i), res[i], pexp[i]);
         check($sformatf("%s latency[%0d]", t, i), res_cyc[i], acc_cyc[i] + 2);
         check($sformatf("%s res_last[%0d]", t, i), res_l[i], (i == n - 1));
      end
   endtask

   initial begin
      int rv_seen, dn_seen;
      sel = 1'b0; racc = 1'b1; start = 1'b0; apx_mode = 1'b0;
      op_valid = 1'b0; op_a = '0; op_b = '0;

      // Test 1: reset, with start asserted to show racc wins
      tick(); start = 1'b1; tick(); tick(); #1;
      check("rst code", o_code, 3'b000);
      check("rst rstP", o_rstP, 1'b1);
      check("rst count0", o_c0, 9'd0);
      check("rst busy", o_busy, 1'b0);
      check("rst done", o_done, 1'b0);
      check("rst op_ready", o_ready, 1'b0);
      check("rst res_valid", o_rvalid, 1'b0);
      check("rst res_last", o_rlast, 1'b0);
      check("rst A_out", o_a, '0);
      check("rst rapx", o_rapx, 1'b0);
      start = 1'b0; racc = 1'b0; tick();

      // Test 2: accurate block
      run_block(1'b0, 1'b0, 0);
      check_block("t2", 3, 3, 4);

      // Test 3: approximate block
      run_block(1'b0, 1'b1, 0);
      check_block("t3", 2, 3, 4);

      // Test 4: two bubbles after the second accepted pair
      run_block(1'b0, 1'b0, 2);
      check_block("t4", 3, 5, 4);

      // Test 5: racc in RUN after two accepted pairs
      sel = 1'b0; apx_mode = 1'b0; op_valid = 1'b1; pi = 0; na = 0; load_pair();
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 300; k++) begin
         #1;
         if (op_valid && o_ready) begin na++; pi++; end
         tick();
         load_pair();
         if (na == 2) break;
      end
      check("t5 accepted_before_abort", na, 2);
      check("t5 in_run", o_code, 3'b011);
      racc = 1'b1; #1;
      check("t5 abort code", o_code, 3'b000);
      check("t5 abort busy", o_busy, 1'b0);
      check("t5 abort rstP", o_rstP, 1'b1);
      check("t5 abort count0", o_c0, 9'd0);
      tick(); racc = 1'b0;
      rv_seen = 0; dn_seen = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (o_rvalid) rv_seen++;
         if (o_done) dn_seen++;
         tick();
      end
      check("t5 res_valid_after_abort", rv_seen, 0);
      check("t5 done_after_abort", dn_seen, 0);
      run_block(1'b0, 1'b0, 0);
      check_block("t5 clean", 3, 3, 4);

      // Test 6: BLK_LEN=1, PRIME straight to DRAIN
      run_block(1'b1, 1'b0, 0);
      check_block("t6", 3, 0, 1);
      check("t6 slot0_accept", acc_cyc[0], 63);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
